// File: rtl/reg_dump_unit.sv
`timescale 1ns/1ps
// reg_dump_unit: walks the register file through its read port and streams each
// register out as an (index, value) word on a valid/ready interface.
module reg_dump_unit #(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned FIRST_REG = 0
) (
    input  logic              i_clk,
    input  logic              i_arst,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_rf_ren,
    output logic [ADDR_W-1:0] o_rf_raddr,
    input  logic [DATA_W-1:0] i_rf_rdata,
    output logic              o_dump_valid,
    input  logic              i_dump_ready,
    output logic [ADDR_W-1:0] o_dump_addr,
    output logic [DATA_W-1:0] o_dump_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0] FirstIdx = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCapture,
        StSend,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [ADDR_W-1:0]   dump_addr_q, dump_addr_d;
    logic [DATA_W-1:0]   dump_data_q, dump_data_d;
    logic                dump_valid_q, dump_valid_d;
    logic [1:0]          rst_sync_q;
    logic                rst_n;
    logic                abort_hit;

    // Reset synchroniser: assertion passes straight through, release waits two edges.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= FirstIdx;
            raddr_q      <= '0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
            dump_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            raddr_q      <= raddr_d;
            dump_addr_q  <= dump_addr_d;
            dump_data_q  <= dump_data_d;
            dump_valid_q <= dump_valid_d;
        end
    end

    assign abort_hit = i_abort &&
                       ((state_q == StRead) || (state_q == StCapture) || (state_q == StSend));

    // Next-state logic; abort overrides whatever the active state decided.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        raddr_d      = raddr_q;
        dump_addr_d  = dump_addr_q;
        dump_data_d  = dump_data_q;
        dump_valid_d = dump_valid_q;

        case (state_q)
            StIdle: begin
                if (i_start) begin
                    idx_d   = FirstIdx;
                    state_d = StRead;
                end
            end
            StRead: begin
                raddr_d = idx_q;
                state_d = StCapture;
            end
            StCapture: begin
                dump_data_d  = i_rf_rdata;
                dump_addr_d  = idx_q;
                dump_valid_d = 1'b1;
                state_d      = StSend;
            end
            StSend: begin
                if (dump_valid_q && i_dump_ready) begin
                    dump_valid_d = 1'b0;
                    // Terminal compare precedes the increment so idx never wraps.
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StRead;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort_hit) begin
            state_d      = StIdle;
            dump_valid_d = 1'b0;
            idx_d        = FirstIdx;
        end
    end

    // Outputs decoded from state; read address holds its last value outside READ.
    always_comb begin
        o_rf_ren     = (state_q == StRead);
        o_rf_raddr   = (state_q == StRead) ? idx_q : raddr_q;
        o_dump_valid = dump_valid_q;
        o_dump_addr  = dump_addr_q;
        o_dump_data  = dump_data_q;
        o_busy       = (state_q != StIdle);
        o_done       = (state_q == StDone);
    end

endmodule

// File: tb/tb_reg_dump_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for reg_dump_unit: expected words are queued when a dump is
// requested and popped by a monitor on every accepted output word.
module tb_reg_dump_unit;

    localparam int NR = 32;
    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } word_t;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          start = 1'b0;
    logic          start1 = 1'b0;
    logic          abort = 1'b0;
    logic          ready = 1'b1;

    logic          ren, ren1, dvalid, dvalid1, busy, busy1, done, done1;
    logic [AW-1:0] raddr, raddr1, daddr, daddr1;
    logic [DW-1:0] rdata, rdata1, ddata, ddata1;

    logic [DW-1:0] rf [NR];

    word_t q0[$];
    word_t q1[$];
    int    exp_done0 = 0;
    int    exp_done1 = 0;
    int    n_chk = 0;
    int    n_pass = 0;
    int    cyc = 0;
    int    last_xfer = -1;
    int    words1 = 0;
    bit    chk_spacing = 1'b0;

    logic          pv = 1'b0;
    logic          phs = 1'b0;
    logic          pab = 1'b0;
    logic [AW-1:0] pa = '0;
    logic [DW-1:0] pd = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: read data valid one cycle after the enable.
    always @(posedge clk) begin
        if (ren)  rdata  <= rf[raddr];
        if (ren1) rdata1 <= rf[raddr1];
    end

    reg_dump_unit #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .FIRST_REG(0)) dut (
        .i_clk(clk), .i_arst(arst), .i_start(start), .i_abort(abort),
        .o_rf_ren(ren), .o_rf_raddr(raddr), .i_rf_rdata(rdata),
        .o_dump_valid(dvalid), .i_dump_ready(ready), .o_dump_addr(daddr),
        .o_dump_data(ddata), .o_busy(busy), .o_done(done)
    );

    reg_dump_unit #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .FIRST_REG(1)) dut1 (
        .i_clk(clk), .i_arst(arst), .i_start(start1), .i_abort(1'b0),
        .o_rf_ren(ren1), .o_rf_raddr(raddr1), .i_rf_rdata(rdata1),
        .o_dump_valid(dvalid1), .i_dump_ready(1'b1), .o_dump_addr(daddr1),
        .o_dump_data(ddata1), .o_busy(busy1), .o_done(done1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a dump is every index from first to NR-1 with its current value.
    task automatic push_dump0();
        word_t w;
        for (int i = 0; i < NR; i++) begin
            w.a = AW'(i);
            w.d = rf[i];
            q0.push_back(w);
        end
        exp_done0++;
    endtask

    task automatic randomize_rf();
        for (int i = 0; i < NR; i++) rf[i] = $urandom;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_word(input int a);
        int n = 0;
        while (!(dvalid && daddr == AW'(a)) && n < 300) begin
            tick();
            n++;
        end
        chk($sformatf("reach_word_%0d", a), n < 300, 1);
    endtask

    task automatic drain(input string name, input bit rnd_ready);
        int n = 0;
        while ((q0.size() != 0 || exp_done0 != 0) && n < 3000) begin
            if (rnd_ready) ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        ready = 1'b1;
        chk({name, "_drained"}, n < 3000, 1);
    endtask

    // Monitor for the FIRST_REG=0 instance.
    always @(negedge clk) begin
        word_t w;
        if (!arst) begin
            pv <= 1'b0;
        end else begin
            if (pv && !phs && !pab) begin
                chk("hold_valid", dvalid, 1);
                chk("hold_addr", daddr, pa);
                chk("hold_data", ddata, pd);
            end
            if (dvalid && ready && !abort) begin
                if (q0.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_word: got addr %0d, expected no word", daddr);
                end else begin
                    w = q0.pop_front();
                    chk("word_addr", daddr, w.a);
                    chk("word_data", ddata, w.d);
                end
                if (chk_spacing && last_xfer >= 0) chk("word_spacing", cyc - last_xfer, 3);
                last_xfer = cyc;
            end
            if (done) begin
                n_chk++;
                if (exp_done0 > 0) begin
                    exp_done0--;
                    n_pass++;
                end else begin
                    $display("FAIL unexpected_done: got done=1 expected 0 at cycle %0d", cyc);
                end
                chk("words_left_at_done", q0.size() % NR, 0);
                if (chk_spacing) chk("done_latency", cyc - last_xfer, 1);
            end
            pv  <= dvalid;
            pa  <= daddr;
            pd  <= ddata;
            phs <= dvalid && ready && !abort;
            pab <= abort;
        end
    end

    // Monitor for the FIRST_REG=1 instance (ready tied high).
    always @(negedge clk) begin
        word_t w;
        if (arst && dvalid1) begin
            words1++;
            if (q1.size() == 0) begin
                n_chk++;
                $display("FAIL fr1_unexpected_word: got addr %0d, expected no word", daddr1);
            end else begin
                w = q1.pop_front();
                chk("fr1_addr", daddr1, w.a);
                chk("fr1_data", ddata1, w.d);
            end
        end
        if (arst && done1) begin
            n_chk++;
            if (exp_done1 > 0) begin
                exp_done1--;
                n_pass++;
            end else begin
                $display("FAIL fr1_unexpected_done: got done=1 expected 0");
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        word_t w;

        // Reset values.
        #1 arst = 1'b0;
        #2;
        chk("rst_ren", ren, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_valid", dvalid, 0);
        chk("rst_daddr", daddr, 0);
        chk("rst_ddata", ddata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        #9 arst = 1'b1;
        repeat (4) tick();

        // Full dump with a known pattern and ready held high.
        for (int i = 0; i < NR; i++) rf[i] = 32'h1000_0000 + i;
        chk_spacing = 1'b1;
        last_xfer = -1;
        push_dump0();
        pulse_start();
        n = 0;
        while (!dvalid && n < 10) begin
            tick();
            n++;
        end
        chk("first_latency", n + 1, 3);
        drain("dump1", 0);
        chk("busy_after_dump", busy, 0);
        chk_spacing = 1'b0;

        // Backpressure on word 7.
        randomize_rf();
        push_dump0();
        pulse_start();
        wait_word(6);
        tick();
        ready = 1'b0;
        wait_word(7);
        repeat (5) tick();
        chk("bp_valid", dvalid, 1);
        chk("bp_addr", daddr, 7);
        chk("bp_data", ddata, rf[7]);
        ready = 1'b1;
        tick();
        chk("bp_valid_after", dvalid, 0);
        drain("dump_bp", 1);

        // Abort coinciding with the handshake of word 10.
        randomize_rf();
        push_dump0();
        pulse_start();
        wait_word(10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", dvalid, 0);
        chk("abort_busy", busy, 0);
        q0.delete();
        exp_done0 = 0;
        repeat (4) tick();
        chk("abort_idle", busy, 0);
        randomize_rf();
        push_dump0();
        pulse_start();
        drain("dump_after_abort", 1);

        // Start ignored mid-dump; start held through DONE re-triggers.
        randomize_rf();
        push_dump0();
        pulse_start();
        wait_word(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_word(31);
        start = 1'b1;
        push_dump0();
        tick();
        chk("done_pulse", done, 1);
        tick();
        chk("gap_busy", busy, 0);
        chk("gap_done", done, 0);
        tick();
        chk("retrigger_ren", ren, 1);
        chk("retrigger_raddr", raddr, 0);
        start = 1'b0;
        drain("dump_retrigger", 1);

        // Asynchronous reset in the middle of SEND.
        ready = 1'b0;
        push_dump0();
        pulse_start();
        wait_word(0);
        #3 arst = 1'b0;
        #1;
        chk("arst_valid", dvalid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_ddata", ddata, 0);
        q0.delete();
        exp_done0 = 0;
        repeat (2) tick();
        #3 arst = 1'b1;
        ready = 1'b1;
        repeat (6) tick();
        chk("arst_busy_after", busy, 0);
        randomize_rf();
        push_dump0();
        pulse_start();
        drain("dump_after_arst", 1);

        // FIRST_REG=1 instance: 31 words starting at index 1.
        randomize_rf();
        for (int i = 1; i < NR; i++) begin
            w.a = AW'(i);
            w.d = rf[i];
            q1.push_back(w);
        end
        exp_done1 = 1;
        words1 = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while ((q1.size() != 0 || exp_done1 != 0) && n < 500) begin
            tick();
            n++;
        end
        chk("fr1_drained", n < 500, 1);
        chk("fr1_count", words1, NR - 1);
        chk("fr1_busy_after", busy1, 0);

        chk("q0_empty", q0.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
